pt2262_tx_scheduler: RTL and testbench
======================================

Name: pt2262_tx_scheduler

Overview:
- Shares one codificador_pt2262 encoder among N_REQ requesters.
- Uses round-robin arbitration, and latches the granted requester's address trits and data nibble.
- Sequences the encoder's reset to send exactly N_REPEAT frames, then inserts an inter-burst gap.
- Sits between application logic and the encoder; the decoder side is untouched.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- N_REPEAT, 4: frames sent per grant (1..15).
- GAP_CYC, 32: idle cycles between bursts, encoder held in reset (>=1).
- WDOG_CYC, 1048576: watchdog limit in cycles between sync pulses (used only with the macro).

Ports:
- clk, in, 1: single system clock, 334 ns period in the bench.
- reset, in, 1: synchronous, active-high reset.
- req_i, in, N_REQ: level request per requester; held until done_o or err_o.
- addr_val_i, in, N_REQ*8: per-requester address bit values; slice i is [8i+7:8i].
- addr_flt_i, in, N_REQ*8: per-requester float mask; 1 means that address bit is driven z.
- data_i, in, N_REQ*4: per-requester data nibble.
- gnt_o, out, N_REQ: one-hot grant, high from latch until burst end.
- done_o, out, N_REQ: one-cycle pulse on successful burst completion.
- err_o, out, N_REQ: one-cycle pulse on watchdog abort (tied 0 without the macro).
- busy_o, out, 1: high in every state except IDLE.
- enc_a_o, out, 8: encoder address; bit k = addr_flt[k] ? z : addr_val[k].
- enc_d_o, out, 4: encoder data.
- enc_reset_o, out, 1: drives the encoder reset, active high.
- enc_sync_i, in, 1: encoder sync; single-cycle pulse at the end of each frame's sync bit.

Behaviour:
- Reset values:
  - gnt_o=0, done_o=0, err_o=0, busy_o=0.
  - enc_reset_o=1, enc_a_o=all z, enc_d_o=0.
  - RR pointer=0, state=IDLE.
- Reset mid-burst:
  - Everything returns to reset values on the next edge.
  - No done_o or err_o pulse is issued.
- States: IDLE, LOAD, SEND, GAP.
- IDLE:
  - enc_reset_o=1.
  - If any req_i is set at edge t, the RR picker selects a winner, starting the search at the pointer and wrapping.
  - At t+1: gnt_o[w]=1, addr/data latched, state=LOAD.
- LOAD:
  - One cycle with enc_reset_o=1 and A/D already stable.
  - Then SEND; enc_reset_o=0 from t+2.
- SEND:
  - Count enc_sync_i pulses; the counter width is clog2(N_REPEAT+1).
  - On the N_REPEAT-th pulse, the next edge gives: enc_reset_o=1, done_o[w]=1 for one cycle, gnt_o=0, pointer=(w+1) mod N_REQ, state=GAP.
- GAP:
  - Count GAP_CYC cycles with enc_reset_o=1, then IDLE.
  - enc_a_o/enc_d_o hold their last values until the next latch.
- Input stability and ignored events:
  - Latched values are immune to requester input changes after grant.
  - Deasserting req_i during SEND does not abort the burst; done_o still pulses.
  - enc_sync_i is ignored outside SEND.
  - New requests are evaluated only in IDLE, so a request made during GAP waits.
- Simultaneous requests: the winner is the first set bit at or after the pointer (e.g. pointer=2, req=4'b1011 -> winner 3).
- Back-to-back: a requester still holding req_i after done_o is eligible again only after the others at or before it in RR order.

Optional Feature:
- Macro: PT2262_TX_WDOG_EN.
- With the macro:
  - A watchdog counter is cleared on entry to SEND and on each enc_sync_i.
  - It counts in SEND only.
  - On reaching WDOG_CYC: err_o[w] pulses for one cycle, done_o stays 0, gnt_o clears, the pointer advances, enc_reset_o=1, state=GAP.
- Without the macro: there is no counter, err_o is constant 0, and SEND waits indefinitely.

Decomposition:
- Package pt2262_pkg holds:
  - the state enum typedef (IDLE, LOAD, SEND, GAP);
  - the address/data width constants ADDR_W=8 and DATA_W=4;
  - defaults for N_REPEAT and GAP_CYC.
- Sub-module rr_arbiter(N): takes req and ptr, returns a one-hot grant and a valid flag; purely combinational.
- The FSM and counters live in the top module.

Test Plan:
- Single request, latch and encode:
  - Stimulus: req_i=4'b0001, addr_val=8'b11001010, addr_flt=8'b00100100, data=4'b1011.
  - Response: enc_a_o=8'b11z01z10, enc_d_o=4'b1011, enc_reset_o falls 2 cycles after req, done_o[0] after exactly 4 sync pulses, then GAP_CYC=32 cycles of enc_reset_o=1.
- Round-robin fairness:
  - Stimulus: req_i=4'b1111 held.
  - Response: grants in order 0,1,2,3,0; exactly one gnt bit high at any time.
- Closed-loop with encoder and decoder:
  - Stimulus: a loopback bench feeding the real encoder and decoder.
  - Response: the decoder asserts dv with D=4'b1011 for each burst.
- Mid-burst reset:
  - Stimulus: reset=1 for 1 cycle after the 2nd sync pulse.
  - Response: all outputs at reset values next cycle, no done_o, and a new burst restarts its count from 0.
- Input change after grant:
  - Stimulus: change data_i[0] and drop req_i[0] during SEND.
  - Response: enc_d_o is unchanged and done_o[0] still pulses.
- Watchdog abort (PT2262_TX_WDOG_EN, WDOG_CYC=100):
  - Stimulus: hold enc_sync_i=0.
  - Response: err_o[w] pulses 100 cycles after entering SEND and done_o stays 0.

Source files
------------

// File: rtl/pt2262_tx_scheduler_pkg.sv
// Shared state encoding and widths for the PT2262 transmit scheduler.
// Any module that needs the FSM states or the encoder widths imports this package.
package pt2262_pkg;
  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 4;
  localparam int N_REPEAT_DEF = 4;
  localparam int GAP_CYC_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;
endpackage

// File: rtl/pt2262_tx_scheduler_if.sv
// Requester-side bus: per-requester request, address/float/data slices, and the
// grant/done/err pulses returned by the scheduler.
interface pt2262_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]                    req_i;
  logic [N_REQ*pt2262_pkg::ADDR_W-1:0] addr_val_i;
  logic [N_REQ*pt2262_pkg::ADDR_W-1:0] addr_flt_i;
  logic [N_REQ*pt2262_pkg::DATA_W-1:0] data_i;
  logic [N_REQ-1:0]                    gnt_o;
  logic [N_REQ-1:0]                    done_o;
  logic [N_REQ-1:0]                    err_o;

  modport master (
    output req_i, addr_val_i, addr_flt_i, data_i,
    input  gnt_o, done_o, err_o
  );

  modport slave (
    input  req_i, addr_val_i, addr_flt_i, data_i,
    output gnt_o, done_o, err_o
  );
endinterface

// File: rtl/pt2262_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Zero latency; vld is simply "any request pending".
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 vld
);
  localparam int PTR_W = $clog2(N);

  always_comb begin
    logic             found;
    logic [PTR_W:0]   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N)) idx = idx - (PTR_W+1)'(N);
      if (!found && req[idx[PTR_W-1:0]]) begin
        gnt[idx[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

  assign vld = |req;
endmodule

// File: rtl/pt2262_tx_scheduler.sv
// Shares one PT2262 encoder among N_REQ requesters: RR grant, latch A/D, N_REPEAT frames, gap.
// Optional watchdog abort on missing sync pulses under `PT2262_TX_WDOG_EN`.
module pt2262_tx_scheduler
  import pt2262_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int N_REPEAT = N_REPEAT_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF
`ifdef PT2262_TX_WDOG_EN
  , parameter int WDOG_CYC = 1048576
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  pt2262_tx_scheduler_if.slave   rq,
  output logic                   busy_o,
  output wire  [ADDR_W-1:0]      enc_a_o,
  output logic [DATA_W-1:0]      enc_d_o,
  output logic                   enc_reset_o,
  input  logic                   enc_sync_i
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(N_REPEAT + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, owner, win_idx, ptr_inc;
  logic [N_REQ-1:0]   arb_gnt;
  logic               arb_vld;
  logic [ADDR_W-1:0]  a_val_q, a_flt_q;
  logic [DATA_W-1:0]  d_q;
  logic [CNT_W-1:0]   rep_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [N_REQ-1:0]   done_q, gnt_c;
  logic               last_sync, gap_last, wdog_fire;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (rq.req_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) if (arb_gnt[i]) win_idx = PTR_W'(i);
  end

  assign ptr_inc   = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign last_sync = enc_sync_i && (rep_cnt == CNT_W'(N_REPEAT - 1));
  assign gap_last  = (gap_cnt == GAP_W'(GAP_CYC - 1));

`ifdef PT2262_TX_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0]  wdog_cnt;
  logic [N_REQ-1:0] err_q;

  // Restarts on every sync so the limit is the spacing between frames, not the burst length.
  always_ff @(posedge clk) begin
    if (reset || state != SEND || enc_sync_i) wdog_cnt <= '0;
    else                                      wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_fire = (state == SEND) && !enc_sync_i && (wdog_cnt == WD_W'(WDOG_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset)          err_q <= '0;
    else begin
      err_q <= '0;
      if (wdog_fire) err_q[owner] <= 1'b1;
    end
  end

  assign rq.err_o = err_q;
`else
  assign wdog_fire = 1'b0;
  assign rq.err_o  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_vld) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (last_sync || wdog_fire) state_nxt = GAP;
      GAP:     if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_c       = '0;
    busy_o      = (state != IDLE);
    enc_reset_o = (state != SEND);
    if (state == LOAD || state == SEND) gnt_c[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      owner   <= '0;
      a_val_q <= '0;
      a_flt_q <= '1;
      d_q     <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      done_q  <= '0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: if (arb_vld) begin
          owner   <= win_idx;
          a_val_q <= rq.addr_val_i[win_idx*ADDR_W +: ADDR_W];
          a_flt_q <= rq.addr_flt_i[win_idx*ADDR_W +: ADDR_W];
          d_q     <= rq.data_i[win_idx*DATA_W +: DATA_W];
        end
        LOAD: rep_cnt <= '0;
        SEND: begin
          if (enc_sync_i) rep_cnt <= rep_cnt + 1'b1;
          if (last_sync) done_q[owner] <= 1'b1;
          if (last_sync || wdog_fire) begin
            ptr     <= ptr_inc;
            gap_cnt <= '0;
          end
        end
        GAP:     gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Floated address bits are released so the encoder sees an open pin.
  for (genvar k = 0; k < ADDR_W; k++) begin : g_addr
    assign enc_a_o[k] = a_flt_q[k] ? 1'bz : a_val_q[k];
  end

  assign enc_d_o   = d_q;
  assign rq.gnt_o  = gnt_c;
  assign rq.done_o = done_q;
endmodule

// File: tb/tb_pt2262_tx_scheduler.sv
// Bench for pt2262_tx_scheduler: vector table, hand sequences and randomized bursts
// against a round-robin reference model; the bench plays the encoder's sync output.
module tb_pt2262_tx_scheduler;
  localparam int N_REQ    = 4;
  localparam int N_REPEAT = 4;
  localparam int GAP_CYC  = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_sync;
  wire  [7:0] enc_a;
  logic [3:0] enc_d;
  logic       enc_reset;
  logic       busy;

  always #167 clk = ~clk;

  pt2262_tx_scheduler_if #(.N_REQ(N_REQ)) rq ();

  pt2262_tx_scheduler #(
    .N_REQ    (N_REQ),
    .N_REPEAT (N_REPEAT),
    .GAP_CYC  (GAP_CYC)
`ifdef PT2262_TX_WDOG_EN
    , .WDOG_CYC (100)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rq          (rq),
    .busy_o      (busy),
    .enc_a_o     (enc_a),
    .enc_d_o     (enc_d),
    .enc_reset_o (enc_reset),
    .enc_sync_i  (enc_sync)
  );

  typedef struct {
    logic [3:0] req;
    logic [7:0] av;
    logic [7:0] fl;
    logic [3:0] d;
    int         exp_w;
    bit         perturb;
  } vec_t;

  vec_t tbl [6];
  int   checks = 0;
  int   errors = 0;
  int   ptr_m  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  function automatic logic [31:0] spread_a(input logic [7:0] v, input bit vary);
    logic [31:0] r;
    for (int i = 0; i < N_REQ; i++) r[i*8 +: 8] = vary ? (v ^ 8'(8'h11 * i)) : v;
    return r;
  endfunction

  function automatic logic [15:0] spread_d(input logic [3:0] v);
    logic [15:0] r;
    for (int i = 0; i < N_REQ; i++) r[i*4 +: 4] = v ^ 4'(i);
    return r;
  endfunction

  // One full burst: grant, LOAD, N_REPEAT frames, done pulse, then the whole gap.
  task automatic run_burst(input logic [3:0] req, input logic [31:0] av, input logic [31:0] fl,
                           input logic [15:0] d, input int w, input bit perturb, input bit hold,
                           input int stall, input string tag);
    logic [7:0] e_av, e_fl;
    logic [3:0] e_d;
    bit         bad;
    int         g;
    e_av = av[w*8 +: 8];
    e_fl = fl[w*8 +: 8];
    e_d  = d[w*4 +: 4];
    rq.req_i = req; rq.addr_val_i = av; rq.addr_flt_i = fl; rq.data_i = d;
    tick();
    check({tag, "/gnt_load"}, rq.gnt_o, 32'(1 << w));
    check({tag, "/busy_load"}, busy, 1);
    check({tag, "/enc_reset_load"}, enc_reset, 1);
    check({tag, "/enc_d_load"}, enc_d, e_d);
    check({tag, "/enc_a_load"}, enc_a & ~e_fl, e_av & ~e_fl);
    enc_sync = 1'b1;  // must be ignored: still in LOAD
    tick();
    enc_sync = 1'b0;
    check({tag, "/enc_reset_send"}, enc_reset, 0);
    bad = 0;
    repeat (stall) begin
      tick();
      if (rq.done_o != 0 || rq.err_o != 0 || enc_reset != 0) bad = 1;
    end
    for (int p = 0; p < N_REPEAT; p++) begin
      repeat ($urandom_range(1, 4)) begin
        tick();
        if (rq.done_o != 0 || rq.err_o != 0 || enc_reset != 0 || rq.gnt_o != 4'(1 << w)) bad = 1;
      end
      if (perturb && p == 2) begin
        rq.data_i = ~d; rq.addr_val_i = ~av;
        if (!hold) rq.req_i = '0;
      end
      enc_sync = 1'b1;
      tick();
      enc_sync = 1'b0;
      if (p < N_REPEAT - 1 && (rq.done_o != 0 || enc_reset != 0)) bad = 1;
    end
    check({tag, "/send_phase"}, bad, 0);
    check({tag, "/done"}, rq.done_o, 32'(1 << w));
    check({tag, "/gnt_end"}, rq.gnt_o, 0);
    check({tag, "/enc_reset_end"}, enc_reset, 1);
    check({tag, "/enc_d_end"}, enc_d, e_d);
    ptr_m = (w + 1) % N_REQ;
    if (!hold) rq.req_i = '0;
    g = 1;
    bad = 0;
    for (int i = 0; i < GAP_CYC + 4; i++) begin
      tick();
      if (!busy) break;
      if (enc_reset != 1 || rq.gnt_o != 0 || rq.done_o != 0 || rq.err_o != 0) bad = 1;
      g++;
    end
    check({tag, "/gap_len"}, g, GAP_CYC);
    check({tag, "/gap_phase"}, bad, 0);
    check({tag, "/enc_d_hold"}, enc_d, e_d);
  endtask

  initial begin
    #(334 * 60000);
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  r;
    logic [31:0] av, fl;
    logic [15:0] d;
    int          w, c;

    tbl[0] = '{4'b0001, 8'b11001010, 8'b00100100, 4'b1011, 0, 1'b1};
    tbl[1] = '{4'b1111, 8'b10101010, 8'b00000000, 4'b0110, 1, 1'b0};
    tbl[2] = '{4'b1011, 8'b01010101, 8'b11110000, 4'b0011, 3, 1'b1};
    tbl[3] = '{4'b0110, 8'b11110000, 8'b00001111, 4'b1100, 1, 1'b0};
    tbl[4] = '{4'b0100, 8'b00110011, 8'b10000001, 4'b1001, 2, 1'b0};
    tbl[5] = '{4'b0011, 8'b11100111, 8'b00011000, 4'b0101, 0, 1'b1};

    reset = 1'b1; enc_sync = 1'b0;
    rq.req_i = '0; rq.addr_val_i = '0; rq.addr_flt_i = '0; rq.data_i = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst/gnt", rq.gnt_o, 0);
    check("rst/done", rq.done_o, 0);
    check("rst/err", rq.err_o, 0);
    check("rst/busy", busy, 0);
    check("rst/enc_reset", enc_reset, 1);
    check("rst/enc_d", enc_d, 0);

    foreach (tbl[i])
      run_burst(tbl[i].req, spread_a(tbl[i].av, 1), spread_a(tbl[i].fl, 0), spread_d(tbl[i].d),
                tbl[i].exp_w, tbl[i].perturb, 1'b0, 0, "tbl");

    // Fairness from a fresh pointer with every requester holding its request.
    reset = 1'b1; tick(); reset = 1'b0; ptr_m = 0;
    for (int n = 0; n < 5; n++)
      run_burst(4'b1111, spread_a(8'h5C, 1), spread_a(8'h00, 0), spread_d(4'h3),
                n % N_REQ, 1'b0, n < 4, 0, "rr");

    // Reset after the second frame: no done, and the next burst needs all frames again.
    rq.req_i = 4'b0100; rq.addr_val_i = 32'h12345678; rq.addr_flt_i = '0; rq.data_i = 16'h9ABC;
    tick(); tick();
    for (int p = 0; p < 2; p++) begin
      tick(); enc_sync = 1'b1; tick(); enc_sync = 1'b0;
    end
    check("midrst/pre_done", rq.done_o, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst/gnt", rq.gnt_o, 0);
    check("midrst/busy", busy, 0);
    check("midrst/enc_reset", enc_reset, 1);
    check("midrst/enc_d", enc_d, 0);
    check("midrst/done", rq.done_o, 0);
    ptr_m = 0;
    run_burst(4'b0100, 32'h12345678, 32'h0, 16'h9ABC, 2, 1'b0, 1'b0, 0, "restart");

`ifdef PT2262_TX_WDOG_EN
    rq.req_i = 4'b0010;
    w = rr_pick(4'b0010, ptr_m);
    tick(); tick();
    c = 0;
    while (c < 300) begin
      tick(); c++;
      if (rq.err_o != 0 || rq.done_o != 0) break;
    end
    check("wdog/cycles", c, 100);
    check("wdog/err", rq.err_o, 32'(1 << w));
    check("wdog/done", rq.done_o, 0);
    check("wdog/gnt", rq.gnt_o, 0);
    check("wdog/enc_reset", enc_reset, 1);
    rq.req_i = '0;
    ptr_m = (w + 1) % N_REQ;
    c = 0;
    while (busy && c < GAP_CYC + 4) begin tick(); c++; end
    check("wdog/gap_len", c, GAP_CYC - 1);
`else
    w = rr_pick(4'b0010, ptr_m);
    run_burst(4'b0010, $urandom, 32'h0, 16'($urandom), w, 1'b0, 1'b0, 150, "stall");
`endif

    for (int n = 0; n < 12; n++) begin
      r  = 4'($urandom_range(1, 15));
      av = $urandom; fl = $urandom; d = 16'($urandom);
      w  = rr_pick(r, ptr_m);
      run_burst(r, av, fl, d, w, bit'($urandom_range(0, 1)), 1'b0, 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
